// File: rtl/rtc_pkg.sv
// Shared definitions for the real-time counter peripheral and its snapshot reader:
// register map, read-sequence states and small address helpers.
package rtc_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARB     = 3'd1,
        S_RD_CTRL = 3'd2,
        S_RD_LO   = 3'd3,
        S_RD_MID  = 3'd4,
        S_RD_HI   = 3'd5,
        S_RD_CHK  = 3'd6,
        S_DONE    = 3'd7
    } rtc_state_e;

    localparam logic [23:0] RTC_CTRL_ADDR = 24'h002008;
    localparam logic [23:0] RTC_SEC0      = 24'h000001;
    localparam logic [23:0] RTC_SEC1      = 24'h000002;
    localparam logic [23:0] RTC_SEC2      = 24'h000003;
    localparam int          READ_PHASES   = 2;

    function automatic logic rtc_is_read(input rtc_state_e st);
        case (st)
            S_RD_CTRL, S_RD_LO, S_RD_MID, S_RD_HI, S_RD_CHK: rtc_is_read = 1'b1;
            default:                                         rtc_is_read = 1'b0;
        endcase
    endfunction

    // The check read revisits the low seconds byte.
    function automatic logic [23:0] rtc_read_offset(input rtc_state_e st);
        case (st)
            S_RD_LO, S_RD_CHK: rtc_read_offset = RTC_SEC0;
            S_RD_MID:          rtc_read_offset = RTC_SEC1;
            S_RD_HI:           rtc_read_offset = RTC_SEC2;
            default:           rtc_read_offset = 24'h000000;
        endcase
    endfunction

endpackage

// File: rtl/rtc_snapshot_reader.sv
// Bus initiator that reads the RTC control and seconds bytes and returns a
// tear-free 24-bit seconds snapshot, re-reading when the low byte moves.
module rtc_snapshot_reader
    import rtc_pkg::*;
#(
    parameter logic [23:0] BASE_ADDR = RTC_CTRL_ADDR,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_ce,
    input  logic        snap_req,
    output logic        snap_valid,
    output logic        snap_error,
    output logic        snap_enabled,
    output logic [23:0] snap_time,
    output logic        bus_request,
    input  logic        bus_grant,
    output logic [23:0] bus_address_out,
    output logic        bus_read,
    input  logic [7:0]  bus_data_in
);

    localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRY);
    localparam logic       PHASE_LAST  = 1'(READ_PHASES - 1);

    rtc_state_e  state_q, state_d;
    logic        phase_q, phase_d;
    logic [1:0]  retry_q, retry_d;
    logic [7:0]  lo_q, lo_d, mid_q, mid_d, hi_q, hi_d;
    logic        en_sh_q, en_sh_d;
    logic [23:0] snap_time_q, snap_time_d;
    logic        snap_en_q, snap_en_d;
    logic        snap_valid_q, snap_valid_d;
    logic        snap_error_q, snap_error_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_rd_q, bus_rd_d;
    logic [23:0] bus_addr_q, bus_addr_d;

    // Next-state, shadow capture and registered-output decode.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        retry_d      = retry_q;
        lo_d         = lo_q;
        mid_d        = mid_q;
        hi_d         = hi_q;
        en_sh_d      = en_sh_q;
        snap_valid_d = 1'b0;
        snap_error_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (snap_req) begin
                    state_d = S_ARB;
                    retry_d = 2'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ARB: begin
                if (bus_grant) begin
                    state_d = S_RD_CTRL;
                    phase_d = 1'b0;
                end else begin
                    state_d = S_ARB;
                end
            end
            S_RD_CTRL, S_RD_LO, S_RD_MID, S_RD_HI, S_RD_CHK: begin
                // Losing the bus discards the sequence; it restarts at control.
                if (!bus_grant) begin
                    state_d = S_ARB;
                    phase_d = 1'b0;
                end else if (phase_q != PHASE_LAST) begin
                    phase_d = phase_q + 1'b1;
                end else begin
                    phase_d = 1'b0;
                    case (state_q)
                        S_RD_CTRL: begin
                            en_sh_d = bus_data_in[0];
                            state_d = S_RD_LO;
                        end
                        S_RD_LO: begin
                            lo_d    = bus_data_in;
                            state_d = S_RD_MID;
                        end
                        S_RD_MID: begin
                            mid_d   = bus_data_in;
                            state_d = S_RD_HI;
                        end
                        S_RD_HI: begin
                            hi_d    = bus_data_in;
                            state_d = S_RD_CHK;
                        end
                        S_RD_CHK: begin
                            if (bus_data_in == lo_q) begin
                                state_d      = S_DONE;
                                snap_valid_d = 1'b1;
                            end else if (retry_q != RETRY_LIMIT) begin
                                retry_d = retry_q + 2'd1;
                                state_d = S_RD_LO;
                            end else begin
                                state_d      = S_DONE;
                                snap_valid_d = 1'b1;
                                snap_error_d = 1'b1;
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (snap_valid_d) begin
            snap_time_d = {hi_q, mid_q, lo_q};
            snap_en_d   = en_sh_q;
        end else begin
            snap_time_d = snap_time_q;
            snap_en_d   = snap_en_q;
        end

        bus_req_d  = (state_d != S_IDLE) && (state_d != S_DONE);
        bus_rd_d   = rtc_is_read(state_d);
        bus_addr_d = bus_rd_d ? (BASE_ADDR + rtc_read_offset(state_d)) : 24'h000000;
    end

    // State and output registers; everything advances only on clock-enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            phase_q      <= 1'b0;
            retry_q      <= 2'd0;
            lo_q         <= 8'h00;
            mid_q        <= 8'h00;
            hi_q         <= 8'h00;
            en_sh_q      <= 1'b0;
            snap_time_q  <= 24'h000000;
            snap_en_q    <= 1'b0;
            snap_valid_q <= 1'b0;
            snap_error_q <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_rd_q     <= 1'b0;
            bus_addr_q   <= 24'h000000;
        end else if (clk_ce) begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            retry_q      <= retry_d;
            lo_q         <= lo_d;
            mid_q        <= mid_d;
            hi_q         <= hi_d;
            en_sh_q      <= en_sh_d;
            snap_time_q  <= snap_time_d;
            snap_en_q    <= snap_en_d;
            snap_valid_q <= snap_valid_d;
            snap_error_q <= snap_error_d;
            bus_req_q    <= bus_req_d;
            bus_rd_q     <= bus_rd_d;
            bus_addr_q   <= bus_addr_d;
        end
    end

    assign snap_valid      = snap_valid_q;
    assign snap_error      = snap_error_q;
    assign snap_enabled    = snap_en_q;
    assign snap_time       = snap_time_q;
    assign bus_request     = bus_req_q;
    assign bus_read        = bus_rd_q;
    assign bus_address_out = bus_addr_q;

endmodule

// File: tb/tb_rtc_snapshot_reader.sv
// Bench for rtc_snapshot_reader: behavioural RTC peripheral, table of snapshot
// vectors checked through a scoreboard, plus grant-loss and async-reset sequences.
module tb_rtc_snapshot_reader;
    import rtc_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clk_ce = 1'b1;
    logic        snap_req = 1'b0;
    logic        bus_grant = 1'b1;
    logic [7:0]  bus_data_in;
    logic        snap_valid, snap_error, snap_enabled, bus_request, bus_read;
    logic [23:0] snap_time, bus_address_out;

    rtc_snapshot_reader dut (
        .clk(clk), .reset_n(reset_n), .clk_ce(clk_ce), .snap_req(snap_req),
        .snap_valid(snap_valid), .snap_error(snap_error), .snap_enabled(snap_enabled),
        .snap_time(snap_time), .bus_request(bus_request), .bus_grant(bus_grant),
        .bus_address_out(bus_address_out), .bus_read(bus_read), .bus_data_in(bus_data_in)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int ce_div = 1;
    int ce_cnt = 0;

    // clock-enable pattern: high on one clock out of every ce_div
    initial begin
        forever begin
            @(negedge clk);
            ce_cnt = (ce_cnt + 1) % ce_div;
            clk_ce = (ce_cnt == 0);
        end
    end

    // peripheral model; mode 0 steady, 1 tears once after the high byte, 2 low byte moves per read
    logic        m_en = 1'b0;
    logic [23:0] m_time = 24'h0, m_time2 = 24'h0, eff;
    int          m_mode = 0;
    int          vec_id = 0, seen_id = 0;
    logic        half = 1'b0, tear_done = 1'b0;
    logic [7:0]  lo_inc = 8'h00;

    always @(posedge clk) begin
        if (seen_id != vec_id) begin
            seen_id   <= vec_id;
            half      <= 1'b0;
            tear_done <= 1'b0;
            lo_inc    <= 8'h00;
        end else if (clk_ce) begin
            if (bus_read) begin
                half <= ~half;
                if (half && bus_address_out == 24'h002009) lo_inc <= lo_inc + 8'd1;
                if (half && bus_address_out == 24'h00200B && m_mode == 1) tear_done <= 1'b1;
            end else begin
                half <= 1'b0;
            end
        end
    end

    always_comb begin
        eff = tear_done ? m_time2 : m_time;
        case (bus_address_out)
            24'h002008: bus_data_in = {7'd0, m_en};
            24'h002009: bus_data_in = eff[7:0] + ((m_mode == 2) ? lo_inc : 8'd0);
            24'h00200A: bus_data_in = eff[15:8];
            24'h00200B: bus_data_in = eff[23:16];
            default:    bus_data_in = 8'h00;
        endcase
    end

    typedef struct {
        logic        en;
        logic [23:0] t;
        logic [23:0] t2;
        int          mode;
        int          div;
        logic [23:0] exp_t;
        logic        exp_en;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [23:0] t;
        logic        en;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    vec_t        vecs[6];
    logic [23:0] addr_seen[$];
    logic [23:0] exp_addr[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic ce_tick();
        do @(posedge clk); while (clk_ce !== 1'b1);
        #1;
    endtask

    task automatic start_req();
        snap_req = 1'b1;
        ce_tick();
        snap_req = 1'b0;
    endtask

    // e counts ce edges already consumed since the request sample edge
    task automatic wait_valid(input int e_in, output int lat);
        int e;
        e = e_in;
        while (snap_valid !== 1'b1 && e < 80) begin
            ce_tick();
            e++;
            if (bus_read === 1'b1) addr_seen.push_back(bus_address_out);
        end
        check("valid_seen", {31'd0, snap_valid}, 32'd1);
        lat = e + 1;
    endtask

    task automatic score(input string tag, input int lat);
        exp_t e;
        int   w;
        e = exp_q.pop_front();
        check({tag, "_time"}, {8'd0, snap_time}, {8'd0, e.t});
        check({tag, "_enabled"}, {31'd0, snap_enabled}, {31'd0, e.en});
        check({tag, "_error"}, {31'd0, snap_error}, {31'd0, e.err});
        check({tag, "_latency"}, lat, e.lat);
        w = 1;
        while (w < 20) begin
            @(posedge clk);
            #1;
            if (snap_valid === 1'b1) w++;
            else break;
        end
        check({tag, "_valid_width"}, w, ce_div);
        check({tag, "_time_hold"}, {8'd0, snap_time}, {8'd0, e.t});
    endtask

    task automatic run_vec(input int idx);
        exp_t e;
        int   lat;
        vec_t v;
        v       = vecs[idx];
        m_en    = v.en;
        m_time  = v.t;
        m_time2 = v.t2;
        m_mode  = v.mode;
        ce_div  = v.div;
        vec_id++;
        e.t   = v.exp_t;
        e.en  = v.exp_en;
        e.err = v.exp_err;
        e.lat = v.exp_lat;
        exp_q.push_back(e);
        addr_seen.delete();
        start_req();
        wait_valid(0, lat);
        score($sformatf("v%0d", idx), lat);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   e;
        int   lat;
        exp_t x;

        // en, time, torn time, mode, ce divisor, expected time/en/err, ce cycle of snap_valid
        vecs[0] = '{1'b1, 24'h123456, 24'h000000, 0, 1, 24'h123456, 1'b1, 1'b0, 12};
        vecs[1] = '{1'b0, 24'hABCDEF, 24'h000000, 0, 1, 24'hABCDEF, 1'b0, 1'b0, 12};
        vecs[2] = '{1'b1, 24'h0000FF, 24'h000100, 1, 1, 24'h000100, 1'b1, 1'b0, 20};
        vecs[3] = '{1'b1, 24'h778810, 24'h000000, 2, 1, 24'h778816, 1'b1, 1'b1, 36};
        vecs[4] = '{1'b1, 24'h00FF00, 24'h000000, 0, 4, 24'h00FF00, 1'b1, 1'b0, 12};
        vecs[5] = '{1'b0, 24'h0000FF, 24'h000100, 1, 4, 24'h000100, 1'b0, 1'b0, 20};
        exp_addr = '{24'h002008, 24'h002008, 24'h002009, 24'h002009, 24'h00200A,
                     24'h00200A, 24'h00200B, 24'h00200B, 24'h002009, 24'h002009};

        repeat (3) @(posedge clk);
        #1;
        check("rst_request", {31'd0, bus_request}, 32'd0);
        check("rst_read", {31'd0, bus_read}, 32'd0);
        check("rst_addr", {8'd0, bus_address_out}, 32'd0);
        check("rst_valid", {31'd0, snap_valid}, 32'd0);
        check("rst_error", {31'd0, snap_error}, 32'd0);
        check("rst_time", {8'd0, snap_time}, 32'd0);
        check("rst_enabled", {31'd0, snap_enabled}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        ce_tick();

        for (int i = 0; i < 6; i++) begin
            run_vec(i);
            if (i == 0) begin
                check("addr_count", addr_seen.size(), 10);
                for (int k = 0; k < 10; k++)
                    check($sformatf("addr_%0d", k), {8'd0, addr_seen[k]}, {8'd0, exp_addr[k]});
            end
        end

        // grant loss during RD_MID phase 1 for three ce cycles
        ce_div  = 1;
        m_en    = 1'b1;
        m_time  = 24'h3C4D5E;
        m_time2 = 24'h000000;
        m_mode  = 0;
        vec_id++;
        x.t = 24'h3C4D5E; x.en = 1'b1; x.err = 1'b0; x.lat = 21;
        exp_q.push_back(x);
        start_req();
        e = 0;
        while (bus_address_out !== 24'h00200A && e < 20) begin
            ce_tick();
            e++;
        end
        check("gl_mid_edge", e, 5);
        ce_tick();
        e++;
        bus_grant = 1'b0;
        ce_tick();
        e++;
        check("gl_arb_request", {31'd0, bus_request}, 32'd1);
        check("gl_arb_read", {31'd0, bus_read}, 32'd0);
        check("gl_arb_addr", {8'd0, bus_address_out}, 32'd0);
        repeat (2) begin
            ce_tick();
            e++;
        end
        check("gl_still_arb_read", {31'd0, bus_read}, 32'd0);
        bus_grant = 1'b1;
        ce_tick();
        e++;
        check("gl_restart_addr", {8'd0, bus_address_out}, 32'h00002008);
        wait_valid(e, lat);
        score("gl", lat);

        // asynchronous reset in the middle of RD_HI
        vec_id++;
        start_req();
        e = 0;
        while (bus_address_out !== 24'h00200B && e < 20) begin
            ce_tick();
            e++;
        end
        check("ar_hi_edge", e, 7);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_request", {31'd0, bus_request}, 32'd0);
        check("ar_read", {31'd0, bus_read}, 32'd0);
        check("ar_addr", {8'd0, bus_address_out}, 32'd0);
        check("ar_time", {8'd0, snap_time}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        ce_tick();
        ce_tick();
        check("ar_idle_request", {31'd0, bus_request}, 32'd0);
        run_vec(0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rtc_snapshot_reader.md
Name: rtc_snapshot_reader

Overview:
- Bus initiator that reads the real-time counter peripheral (control 0x2008, timer bytes 0x2009..0x200B) from the peripheral side of the system bus.
- Returns a tear-free 24-bit seconds value plus the enable bit to the host/bridge logic, for save-state and RTC persistence.
- Sits between the bus arbiter and the host bridge. Uses the same clk/clk_ce domain as the peripheral bus.

Parameters:
- BASE_ADDR, 24'h2008, address of the RTC control register; timer bytes are at BASE_ADDR+1..+3.
- MAX_RETRY, 3, number of re-read attempts on tear detection before reporting an error (2-bit counter range).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- clk_ce  in  1  clock enable; all state advances only when high
- snap_req  in  1  host request; level, sampled in IDLE
- snap_valid  out  1  one-ce-cycle pulse, result ready
- snap_error  out  1  valid with snap_valid; retries exhausted
- snap_enabled  out  1  captured control bit 0
- snap_time  out  24  captured timer value {hi,mid,lo}
- bus_request  out  1  request to arbiter
- bus_grant  in  1  arbiter grant
- bus_address_out  out  24  read address; 0 when not granted
- bus_read  out  1  read strobe during read states
- bus_data_in  in  8  read data from the peripheral (combinational decode)

Behaviour:
- Reset (async, reset_n low): FSM=IDLE; all outputs 0; snap_time/snap_enabled 0; retry counter 0. Mid-sequence reset aborts immediately and drops bus_request the same instant.
- All transitions occur on posedge clk with clk_ce=1; with clk_ce=0 the state holds.
- States: IDLE, ARB, RD_CTRL, RD_LO, RD_MID, RD_HI, RD_CHK, DONE.
- IDLE: snap_req=1 -> ARB. Clear the retry counter.
- ARB: bus_request=1. Wait for bus_grant=1, then go to RD_CTRL, phase 0.
- Read states:
  - Each read state lasts 2 ce cycles (phase 0, phase 1).
  - bus_address_out and bus_read are driven in both phases.
  - bus_data_in is captured at the end of phase 1.
  - Addresses: RD_CTRL=BASE, RD_LO=BASE+1, RD_MID=+2, RD_HI=+3, RD_CHK=BASE+1.
  - RD_CTRL captures bit 0 into snap_enabled.
  - RD_LO/MID/HI capture into lo/mid/hi shadow registers.
- RD_CHK compares the re-read low byte against the lo shadow:
  - Equal -> DONE.
  - Different and retry count < MAX_RETRY -> increment count, go to RD_LO phase 0 (control is not re-read).
  - Different and count == MAX_RETRY -> DONE with error flag set.
- DONE (1 ce cycle):
  - snap_valid=1. snap_time={hi,mid,lo} from the shadows (last attempt on error).
  - snap_error as determined in RD_CHK.
  - bus_request=0 in DONE. Next state IDLE.
- Output holding:
  - snap_time and snap_enabled hold their values until the next DONE.
  - snap_valid and snap_error are 0 outside DONE.
- Grant loss: if bus_grant=0 in any read state, return to ARB, discard the phase, and restart from RD_CTRL on re-grant. Grant loss does not consume a retry. bus_read=0 while in ARB.
- Latency: grant held from ARB entry gives 1 (ARB) + 10 (reads) + 1 (DONE) = 12 ce cycles from the req sample to snap_valid. Each retry adds 8 ce cycles.
- snap_req held high re-arms from IDLE on the ce after DONE. Back-to-back snapshots therefore have one IDLE cycle between them.
- Address arithmetic: 24-bit, wrap ignored (BASE is a fixed constant).

Decomposition:
- Shared package rtc_pkg holds:
  - the state enum;
  - RTC_CTRL_ADDR=24'h2008, RTC_SEC0/1/2 offsets;
  - READ_PHASES=2.
- The RTC peripheral and this reader both import the address constants.
- Single module; no sub-module. The FSM, shadows and retry counter are small enough to stay inline.

Test Plan:
- Basic snapshot: peripheral model enable=1, timer=24'h12_3456, grant tied 1, pulse snap_req -> snap_valid at ce 12; snap_time=24'h123456, snap_enabled=1, snap_error=0; address sequence 2008,2008,2009,2009,200A,200A,200B,200B,2009,2009.
- Tear retry: model bumps timer 24'h0000FF -> 24'h000100 between the RD_LO and RD_CHK captures, once -> one retry (8 extra ce); result 24'h000100, error=0.
- Retry exhaustion with MAX_RETRY=3: model changes the low byte on every read -> 4 compare failures, then snap_valid with snap_error=1 at ce 12+24=36.
- Grant loss: drop bus_grant during RD_MID phase 1 for 3 ce cycles -> bus_read=0 and bus_request=1 in ARB; sequence restarts at 0x2008; correct value returned; retry count unaffected.
- clk_ce gating: clk_ce=1 every 4th clk -> identical address/state sequence per ce; snap_valid is high for exactly one ce period.
- Async reset: assert reset_n=0 mid-RD_HI between clock edges -> bus_request, bus_read and bus_address_out are 0 immediately; after release the FSM is in IDLE and a new req completes normally.
